// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/opcode request side and registered result side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [3:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, x, y, operation, out_ready,
    input  in_ready, out_valid, out, carry, zero
  );

  modport slave (
    input  in_valid, x, y, operation, out_ready,
    output in_ready, out_valid, out, carry, zero
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags, iterative N-bit shifts.
// Optional iterative shift-add multiplier on opcode C when ALU_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int SH_W = $clog2(WIDTH) + 1;
  localparam logic [SH_W-1:0] NMAX = SH_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ASSIGN = 4'h0, OP_OR   = 4'h1, OP_AND  = 4'h2, OP_XOR  = 4'h3,
    OP_ADD    = 4'h4, OP_SUB  = 4'h5, OP_SHR1 = 4'h6, OP_RSUB = 4'h7,
    OP_ADC    = 4'h8, OP_SBC  = 4'h9, OP_SHLN = 4'hA, OP_SHRN = 4'hB,
    OP_MUL    = 4'hC, OP_RSVD = 4'hD, OP_RSVE = 4'hE, OP_SHL1 = 4'hF
  } op_e;

  state_e           state;
  logic [WIDTH-1:0] out_r;
  logic             carry_r;
  logic             zero_r;
  logic [WIDTH-1:0] sh;
  logic [SH_W-1:0]  cnt;
  logic             left;

  op_e              op;
  logic [SH_W-1:0]  n_raw;
  logic [SH_W-1:0]  n;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_bit;
  logic [WIDTH-1:0] step_val;
  logic             step_c;

`ifdef ALU_MUL_EN
  logic               mul;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_nxt;
`endif

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_r;
  assign bus.carry     = carry_r;
  assign bus.zero      = zero_r;

  assign op    = op_e'(bus.operation);
  assign n_raw = bus.y[SH_W-1:0];
  assign n     = (n_raw > NMAX) ? NMAX : n_raw;

  // Single-cycle result path, evaluated on the accepting edge.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    diff  = '0;
    case (op)
      OP_ASSIGN: res = bus.y;
      OP_OR:     res = bus.x | bus.y;
      OP_AND:    res = bus.x & bus.y;
      OP_XOR:    res = bus.x ^ bus.y;
      OP_ADD:    {res_c, res} = {1'b0, bus.x} + {1'b0, bus.y};
      OP_ADC:    {res_c, res} = {1'b0, bus.x} + {1'b0, bus.y} + {{WIDTH{1'b0}}, carry_r};
      OP_SUB: begin
        diff  = {1'b0, bus.x} - {1'b0, bus.y};
        res   = diff[WIDTH-1:0];
        res_c = ~diff[WIDTH];
      end
      OP_RSUB: begin
        diff  = {1'b0, bus.y} - {1'b0, bus.x};
        res   = diff[WIDTH-1:0];
        res_c = ~diff[WIDTH];
      end
      OP_SBC: begin
        diff  = {1'b0, bus.x} - {1'b0, bus.y} - {{WIDTH{1'b0}}, ~carry_r};
        res   = diff[WIDTH-1:0];
        res_c = ~diff[WIDTH];
      end
      OP_SHR1: begin
        res   = {1'b0, bus.x[WIDTH-1:1]};
        res_c = bus.x[0];
      end
      OP_SHL1: begin
        res   = {bus.x[WIDTH-2:0], 1'b0};
        res_c = bus.x[WIDTH-1];
      end
      OP_SHLN, OP_SHRN: res = bus.x;
      default: ;
    endcase
  end

  // One iteration of the BUSY state; the multiplier reuses sh as its right-shifting multiplier.
  always_comb begin
    sh_nxt = left ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    sh_bit = left ? sh[WIDTH-1] : sh[0];
`ifdef ALU_MUL_EN
    acc_nxt = sh[0] ? (acc + mcand) : acc;
    if (mul) begin
      step_val = acc_nxt[WIDTH-1:0];
      step_c   = |acc_nxt[2*WIDTH-1:WIDTH];
    end else
`endif
    begin
      step_val = sh_nxt;
      step_c   = sh_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out_r   <= '0;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      sh      <= '0;
      cnt     <= '0;
      left    <= 1'b0;
`ifdef ALU_MUL_EN
      mul     <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.in_valid && bus.in_ready) begin
            sh   <= bus.x;
            left <= (op == OP_SHLN);
`ifdef ALU_MUL_EN
            mul  <= 1'b0;
`endif
            if ((op == OP_SHLN || op == OP_SHRN) && n != '0) begin
              cnt   <= n;
              state <= BUSY;
            end
`ifdef ALU_MUL_EN
            else if (op == OP_MUL) begin
              sh    <= bus.y;
              mcand <= {{WIDTH{1'b0}}, bus.x};
              acc   <= '0;
              mul   <= 1'b1;
              left  <= 1'b0;
              cnt   <= NMAX;
              state <= BUSY;
            end
`endif
            else begin
              out_r   <= res;
              carry_r <= res_c;
              zero_r  <= (res == '0);
              state   <= DONE;
            end
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          sh  <= sh_nxt;
          cnt <= cnt - 1'b1;
`ifdef ALU_MUL_EN
          acc   <= acc_nxt;
          mcand <= mcand << 1;
`endif
          if (cnt == SH_W'(1)) begin
            out_r   <= step_val;
            carry_r <= step_c;
            zero_r  <= (step_val == '0);
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor pops on out_valid.
module tb_alu_seq;
  localparam int W    = 8;
  localparam int SH_W = $clog2(W) + 1;
  localparam longint M = longint'(1) << W;

  typedef struct {
    longint r;
    longint c;
    longint z;
    longint rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  longint mc = 0;
  int   stall_req = 0;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour from the opcode table, plain integer arithmetic.
  function automatic void model(input int op, input longint a, input longint b,
                                inout longint c, output longint r, output longint lat);
    longint s;
    longint nn;
    lat = 0;
    r   = 0;
    case (op)
      0:  begin r = b; c = 0; end
      1:  begin r = a | b; c = 0; end
      2:  begin r = a & b; c = 0; end
      3:  begin r = a ^ b; c = 0; end
      4:  begin s = a + b; r = s % M; c = (s >= M) ? 1 : 0; end
      5:  begin r = (a - b + M) % M; c = (a >= b) ? 1 : 0; end
      6:  begin r = a / 2; c = a % 2; end
      7:  begin r = (b - a + M) % M; c = (b >= a) ? 1 : 0; end
      8:  begin s = a + b + c; r = s % M; c = (s >= M) ? 1 : 0; end
      9:  begin s = a - b - (1 - c); r = (s + 2 * M) % M; c = (s >= 0) ? 1 : 0; end
      10, 11: begin
        nn = b % (longint'(1) << SH_W);
        if (nn > W) nn = W;
        lat = nn;
        if (nn == 0) begin r = a; c = 0; end
        else if (op == 10) begin r = (a << nn) % M; c = (a >> (W - nn)) & 1; end
        else begin r = a >> nn; c = (a >> (nn - 1)) & 1; end
      end
`ifdef ALU_MUL_EN
      12: begin s = a * b; r = s % M; c = (s >= M) ? 1 : 0; lat = W; end
`endif
      15: begin r = (a * 2) % M; c = (a >> (W - 1)) & 1; end
      default: begin r = 0; c = 0; end
    endcase
  endfunction

  task automatic issue(input int op, input longint a, input longint b);
    exp_t   e;
    longint r, lat;
    bit     acc = 0;
    bus.in_valid  = 1'b1;
    bus.operation = 4'(op);
    bus.x         = W'(a);
    bus.y         = W'(b);
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        model(op, a, b, mc, r, lat);
        e.r = r; e.c = mc; e.z = (r == 0) ? 1 : 0;
        e.rdy = cyc + 1 + lat;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    bus.in_valid  = 1'b0;
    bus.operation = 4'($urandom);
    bus.x         = W'($urandom);
    bus.y         = W'($urandom);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 500 && (q.size() != 0 || bus.out_valid); i++) begin
      @(posedge clk); #1;
    end
    if (i == 500) chk("drain_timeout", 0, 1);
  endtask

  // Monitor: pops an expectation on each new result, checks hold stability under back-pressure.
  initial begin
    exp_t e;
    bit   holding = 0;
    bit   have_exp = 0;
    bit   rel = 0;
    int   stalling = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (holding && !bus.out_valid) begin
        chk("hold_valid", 0, 1);
        holding = 0;
      end
      if (bus.out_valid) begin
        if (!holding) begin
          holding = 1;
          if (q.size() == 0) begin
            chk("unexpected_result", 1, 0);
            have_exp = 0;
          end else begin
            e = q.pop_front();
            have_exp = 1;
            chk("out", longint'(bus.out), e.r);
            chk("carry", longint'(bus.carry), e.c);
            chk("zero", longint'(bus.zero), e.z);
            chk("latency", longint'(cyc), e.rdy);
          end
          stalling = stall_req;
          stall_req = 0;
        end else if (have_exp) begin
          chk("hold_out", longint'(bus.out), e.r);
          chk("hold_carry", longint'(bus.carry), e.c);
          chk("hold_zero", longint'(bus.zero), e.z);
          if (!bus.out_ready) chk("hold_in_ready", longint'(bus.in_ready), 0);
        end
      end
      if (stalling > 0) begin
        bus.out_ready = 1'b0;
        stalling--;
        if (stalling == 0) rel = 1;
      end else if (rel) begin
        bus.out_ready = 1'b1;
        rel = 0;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.out_valid && bus.out_ready) holding = 0;
    end
  end

  initial begin
    int op;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.operation = '0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out", longint'(bus.out), 0);
    chk("rst_carry", longint'(bus.carry), 0);
    chk("rst_zero", longint'(bus.zero), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1;

    issue(4, 'hF0, 'h20);
    issue(4, 'hFF, 'h01);
    issue(8, 'h00, 'h00);
    issue(9, 'h05, 'h05);
    issue(10, 'h81, 'h03);
    issue(11, 'h81, 'h01);
    issue(10, 'h81, 'h0F);
    issue(10, 'h81, 'h00);
    issue(12, 'h10, 'h11);
    issue(12, 'h03, 'h04);
    issue(13, 'h55, 'h66);
    drain();

    stall_req = 5;
    issue(4, 'h12, 'h34);
    issue(3, 'h0F, 'hFF);
    issue(1, 'h00, 'h00);
    drain();

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 15);
      issue(op, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    // Abort an 8-step shift in its 4th BUSY cycle.
    issue(10, 'h81, 'h0F);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", longint'(bus.out_valid), 0);
    chk("abort_out", longint'(bus.out), 0);
    chk("abort_carry", longint'(bus.carry), 0);
    chk("abort_zero", longint'(bus.zero), 0);
    void'(q.pop_back());
    mc = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    issue(4, 'h01, 'h01);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
